active_list: RTL and testbench

- In-order reorder buffer ("active list") at the other end of the instruction-queue flush protocol.
- Allocates one entry per renamed instruction and returns the entry index, which the issue queue stores as active_List_Index.
- Takes out-of-order completion reports and commits in program order, returning freed physical registers to the free list.
- On a committed mispredict, produces the flush ID, then walks back uncommitted entries over several cycles to undo renaming; flush_done tells the issue queue it may accept new instructions again.

---
 rtl/mips_core_pkg.sv | 31 +++
 rtl/active_list.sv | 163 ++++++++++++++++
 tb/tb_active_list.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// Shared types for the core: active list entry layout and walk-back state.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    localparam int AL_DEPTH  = 32;
    localparam int AL_IDX_W  = 5;
    localparam int AL_PREG_W = 6;
    localparam int AL_AREG_W = 5;
    localparam int AL_ID_W   = `ADDR_WIDTH;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic                 mispredict;
        logic [AL_ID_W-1:0]   id;
        logic                 uses_rw;
        logic [AL_AREG_W-1:0] areg;
        logic [AL_PREG_W-1:0] new_preg;
        logic [AL_PREG_W-1:0] old_preg;
    } al_entry_t;

    typedef enum logic [1:0] {
        AL_RUN  = 2'd0,
        AL_WALK = 2'd1,
        AL_DONE = 2'd2
    } al_state_e;

endpackage

// File: rtl/active_list.sv
// In-order reorder buffer: allocates at tail, retires at head, and on a
// committed mispredict walks younger entries back youngest-first.
//
// state   | meaning
// AL_RUN  | normal dispatch / completion / in-order commit
// AL_WALK | undo one uncommitted entry per cycle from the tail
// AL_DONE | one-cycle flush_done pulse, then back to AL_RUN
module active_list
    import mips_core_pkg::*;
#(
    parameter int DEPTH  = AL_DEPTH,
    parameter int IDX_W  = AL_IDX_W,
    parameter int PREG_W = AL_PREG_W,
    parameter int AREG_W = AL_AREG_W,
    parameter int ID_W   = `ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [ID_W-1:0]   disp_id,
    input  logic              disp_uses_rw,
    input  logic [AREG_W-1:0] disp_areg,
    input  logic [PREG_W-1:0] disp_new_preg,
    input  logic [PREG_W-1:0] disp_old_preg,
    output logic [IDX_W-1:0]  alloc_index,
    input  logic              cmpl_valid,
    input  logic [IDX_W-1:0]  cmpl_index,
    input  logic              cmpl_mispredict,
    output logic              commit_valid,
    output logic              commit_free_valid,
    output logic [PREG_W-1:0] commit_free_preg,
    output logic              flush,
    output logic [ID_W-1:0]   flushed_instruction_ID,
    output logic              rollback_valid,
    output logic [AREG_W-1:0] rollback_areg,
    output logic [PREG_W-1:0] rollback_old_preg,
    output logic [PREG_W-1:0] rollback_new_preg,
    output logic              flush_done,
    output logic              empty
);

    localparam logic [IDX_W:0] LP_FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] LP_ONE  = (IDX_W+1)'(1);

    al_entry_t        r_entries [DEPTH];
    al_state_e        r_state;
    al_state_e        w_state_nxt;
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;
    logic [ID_W-1:0]  r_flush_id;

    al_entry_t        w_head_e;
    al_entry_t        w_rb_e;
    al_entry_t        w_new_e;
    logic [IDX_W-1:0] w_tail_m1;
    logic             w_run;
    logic             w_walk;
    logic             w_commit;
    logic             w_flush;
    logic             w_disp_ready;
    logic             w_disp;
    logic             w_cmpl;

    always_comb begin
        w_run        = (r_state == AL_RUN);
        w_walk       = (r_state == AL_WALK);
        w_tail_m1    = r_tail - 1'b1;
        w_head_e     = r_entries[r_head];
        w_rb_e       = r_entries[w_tail_m1];
        w_commit     = w_run && w_head_e.valid && w_head_e.done;
        w_flush      = w_commit && w_head_e.mispredict;
        // Held low while reset is asserted so every handshake output is quiet.
        w_disp_ready = !rst && w_run && (r_count != LP_FULL);
        // A dispatch arriving in the flush cycle belongs to the wrong path.
        w_disp       = disp_valid && w_disp_ready && !w_flush;
        w_cmpl       = w_run && cmpl_valid && r_entries[cmpl_index].valid;

        w_new_e          = '0;
        w_new_e.valid    = 1'b1;
        w_new_e.id       = disp_id;
        w_new_e.uses_rw  = disp_uses_rw;
        w_new_e.areg     = disp_areg;
        w_new_e.new_preg = disp_new_preg;
        w_new_e.old_preg = disp_old_preg;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            AL_RUN: begin
                if (w_flush) begin
                    w_state_nxt = (r_count == LP_ONE) ? AL_DONE : AL_WALK;
                end
            end
            AL_WALK: begin
                if (r_count == LP_ONE) begin
                    w_state_nxt = AL_DONE;
                end
            end
            AL_DONE: w_state_nxt = AL_RUN;
            default: w_state_nxt = AL_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= AL_RUN;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_flush_id <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_flush) begin
                r_flush_id <= w_head_e.id;
            end
            if (w_cmpl) begin
                r_entries[cmpl_index].done       <= 1'b1;
                r_entries[cmpl_index].mispredict <= cmpl_mispredict;
            end
            if (w_disp) begin
                r_entries[r_tail] <= w_new_e;
                r_tail            <= r_tail + 1'b1;
            end
            if (w_commit) begin
                r_entries[r_head] <= '0;
                r_head            <= r_head + 1'b1;
            end
            if (w_walk) begin
                r_entries[w_tail_m1] <= '0;
                r_tail               <= w_tail_m1;
            end

            if (w_walk) begin
                r_count <= r_count - 1'b1;
            end else if (w_disp && !w_commit) begin
                r_count <= r_count + 1'b1;
            end else if (!w_disp && w_commit) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign disp_ready             = w_disp_ready;
    assign alloc_index            = r_tail;
    assign commit_valid           = w_commit;
    assign commit_free_valid      = w_commit && w_head_e.uses_rw;
    assign commit_free_preg       = w_commit ? w_head_e.old_preg : '0;
    assign flush                  = w_flush;
    assign flushed_instruction_ID = w_flush ? w_head_e.id : r_flush_id;
    assign rollback_valid         = w_walk;
    assign rollback_areg          = w_walk ? w_rb_e.areg : '0;
    assign rollback_old_preg      = w_walk ? w_rb_e.old_preg : '0;
    assign rollback_new_preg      = w_walk ? w_rb_e.new_preg : '0;
    assign flush_done             = (r_state == AL_DONE);
    assign empty                  = (r_count == '0);

endmodule

// File: tb/tb_active_list.sv
// Vector-table bench for active_list with an in-order scoreboard of dispatched IDs.
module tb_active_list;

    localparam int IDX_W  = 5;
    localparam int PREG_W = 6;
    localparam int AREG_W = 5;
    localparam int ID_W   = mips_core_pkg::AL_ID_W;

    logic              clk;
    logic              rst;
    logic              disp_valid;
    logic              disp_ready;
    logic [ID_W-1:0]   disp_id;
    logic              disp_uses_rw;
    logic [AREG_W-1:0] disp_areg;
    logic [PREG_W-1:0] disp_new_preg;
    logic [PREG_W-1:0] disp_old_preg;
    logic [IDX_W-1:0]  alloc_index;
    logic              cmpl_valid;
    logic [IDX_W-1:0]  cmpl_index;
    logic              cmpl_mispredict;
    logic              commit_valid;
    logic              commit_free_valid;
    logic [PREG_W-1:0] commit_free_preg;
    logic              flush;
    logic [ID_W-1:0]   flushed_instruction_ID;
    logic              rollback_valid;
    logic [AREG_W-1:0] rollback_areg;
    logic [PREG_W-1:0] rollback_old_preg;
    logic [PREG_W-1:0] rollback_new_preg;
    logic              flush_done;
    logic              empty;

    active_list dut (
        .clk                    (clk),
        .rst                    (rst),
        .disp_valid             (disp_valid),
        .disp_ready             (disp_ready),
        .disp_id                (disp_id),
        .disp_uses_rw           (disp_uses_rw),
        .disp_areg              (disp_areg),
        .disp_new_preg          (disp_new_preg),
        .disp_old_preg          (disp_old_preg),
        .alloc_index            (alloc_index),
        .cmpl_valid             (cmpl_valid),
        .cmpl_index             (cmpl_index),
        .cmpl_mispredict        (cmpl_mispredict),
        .commit_valid           (commit_valid),
        .commit_free_valid      (commit_free_valid),
        .commit_free_preg       (commit_free_preg),
        .flush                  (flush),
        .flushed_instruction_ID (flushed_instruction_ID),
        .rollback_valid         (rollback_valid),
        .rollback_areg          (rollback_areg),
        .rollback_old_preg      (rollback_old_preg),
        .rollback_new_preg      (rollback_new_preg),
        .flush_done             (flush_done),
        .empty                  (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          rst_b4;
        bit          dv;
        int unsigned id;
        bit          cv;
        int unsigned ci;
        bit          cm;
        bit          e_ready;
        int unsigned e_alloc;
        bit          e_commit;
        bit          e_empty;
        bit          e_flush;
        bit          e_rb;
        bit          e_fdone;
        bit          chk_fid;
        int unsigned fid;
    } vec_t;

    vec_t        vecs[$];
    int unsigned sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Per-instruction payload is a fixed function of the ID so the scoreboard only holds IDs.
    function automatic logic f_uses(input int unsigned id);
        return id[0];
    endfunction
    function automatic logic [AREG_W-1:0] f_areg(input int unsigned id);
        int unsigned t;
        t = id ^ 32'h3;
        return t[AREG_W-1:0];
    endfunction
    function automatic logic [PREG_W-1:0] f_newp(input int unsigned id);
        int unsigned t;
        t = id + 7;
        return t[PREG_W-1:0];
    endfunction
    function automatic logic [PREG_W-1:0] f_oldp(input int unsigned id);
        int unsigned t;
        t = id + 3;
        return t[PREG_W-1:0];
    endfunction

    function automatic vec_t mk(input string nm, input bit dv, input int unsigned id,
                                input bit cv, input int unsigned ci, input bit cm,
                                input bit e_ready, input int unsigned e_alloc, input bit e_commit,
                                input bit e_empty, input bit e_flush, input bit e_rb, input bit e_fdone);
        vec_t v;
        v.nm = nm; v.rst_b4 = 1'b0; v.dv = dv; v.id = id; v.cv = cv; v.ci = ci; v.cm = cm;
        v.e_ready = e_ready; v.e_alloc = e_alloc; v.e_commit = e_commit; v.e_empty = e_empty;
        v.e_flush = e_flush; v.e_rb = e_rb; v.e_fdone = e_fdone; v.chk_fid = 1'b0; v.fid = 0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        disp_valid = 0; disp_id = '0; disp_uses_rw = 0; disp_areg = '0;
        disp_new_preg = '0; disp_old_preg = '0;
        cmpl_valid = 0; cmpl_index = '0; cmpl_mispredict = 0;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        zero_inputs();
        #1;
        chk({nm, ".rst_ready"},  64'(disp_ready), 64'd0);
        chk({nm, ".rst_empty"},  64'(empty), 64'd1);
        chk({nm, ".rst_alloc"},  64'(alloc_index), 64'd0);
        chk({nm, ".rst_commit"}, 64'(commit_valid), 64'd0);
        chk({nm, ".rst_flush"},  64'(flush), 64'd0);
        chk({nm, ".rst_rb"},     64'(rollback_valid), 64'd0);
        chk({nm, ".rst_rbpreg"}, 64'(rollback_new_preg), 64'd0);
        chk({nm, ".rst_fid"},    64'(flushed_instruction_ID), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk({nm, ".rst_fdone"}, 64'(flush_done), 64'd0);
        end
        rst = 1'b0;
        sb.delete();
        #1;
        chk({nm, ".post_rst_ready"}, 64'(disp_ready), 64'd1);
    endtask

    task automatic apply(input vec_t v);
        int unsigned e;
        if (v.rst_b4) do_reset(v.nm);
        disp_valid      = v.dv;
        disp_id         = ID_W'(v.id);
        disp_uses_rw    = f_uses(v.id);
        disp_areg       = f_areg(v.id);
        disp_new_preg   = f_newp(v.id);
        disp_old_preg   = f_oldp(v.id);
        cmpl_valid      = v.cv;
        cmpl_index      = IDX_W'(v.ci);
        cmpl_mispredict = v.cm;
        #1;
        chk({v.nm, ".ready"},  64'(disp_ready), 64'(v.e_ready));
        chk({v.nm, ".alloc"},  64'(alloc_index), 64'(v.e_alloc));
        chk({v.nm, ".commit"}, 64'(commit_valid), 64'(v.e_commit));
        chk({v.nm, ".empty"},  64'(empty), 64'(v.e_empty));
        chk({v.nm, ".flush"},  64'(flush), 64'(v.e_flush));
        chk({v.nm, ".rb"},     64'(rollback_valid), 64'(v.e_rb));
        chk({v.nm, ".fdone"},  64'(flush_done), 64'(v.e_fdone));
        if (v.chk_fid) chk({v.nm, ".fid_held"}, 64'(flushed_instruction_ID), 64'(v.fid));
        if (commit_valid) begin
            if (sb.size() == 0) begin
                chk({v.nm, ".sb_commit_underflow"}, 64'(commit_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk({v.nm, ".free_valid"}, 64'(commit_free_valid), 64'(f_uses(e)));
                chk({v.nm, ".free_preg"},  64'(commit_free_preg), 64'(f_oldp(e)));
                if (flush) chk({v.nm, ".fid"}, 64'(flushed_instruction_ID), 64'(e));
            end
        end
        if (rollback_valid) begin
            if (sb.size() == 0) begin
                chk({v.nm, ".sb_rb_underflow"}, 64'(rollback_valid), 64'd0);
            end else begin
                e = sb.pop_back();
                chk({v.nm, ".rb_areg"}, 64'(rollback_areg), 64'(f_areg(e)));
                chk({v.nm, ".rb_old"},  64'(rollback_old_preg), 64'(f_oldp(e)));
                chk({v.nm, ".rb_new"},  64'(rollback_new_preg), 64'(f_newp(e)));
            end
        end
        if (v.dv && v.e_ready && !v.e_flush) sb.push_back(v.id);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
        $fatal(1);
    end

    initial begin
        vec_t t;
        rst = 1'b1;
        zero_inputs();

        // Basic dispatch and out-of-order completion, in-order commit.
        t = mk("d10", 1, 10, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0); t.rst_b4 = 1; vecs.push_back(t);
        vecs.push_back(mk("d11",   1, 11, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("d12",   1, 12, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk("c1",    0, 0,  1, 1, 0, 1, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk("c0",    0, 0,  1, 0, 0, 1, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk("k10",   0, 0,  0, 0, 0, 1, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk("k11",   0, 0,  0, 0, 0, 1, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk("hold2", 0, 0,  0, 0, 0, 1, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk("c2",    0, 0,  1, 2, 0, 1, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk("k12",   0, 0,  0, 0, 0, 1, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk("emp",   0, 0,  0, 0, 0, 1, 3, 0, 1, 0, 0, 0));

        // Fill to full, commit while full with dispatch held, then wrap.
        for (int i = 0; i < 32; i++) begin
            t = mk("fill", 1, 100 + i, 0, 0, 0, 1, i, 0, (i == 0), 0, 0, 0);
            t.rst_b4 = (i == 0);
            vecs.push_back(t);
        end
        vecs.push_back(mk("full",  1, 200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("fullc", 1, 200, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("fullk", 1, 200, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("wrap",  1, 200, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("wrap2", 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        // Mispredict with four younger entries: walk-back and flush_done latency.
        for (int i = 0; i < 5; i++) begin
            t = mk("md", 1, 20 + i, 0, 0, 0, 1, i, 0, (i == 0), 0, 0, 0);
            t.rst_b4 = (i == 0);
            vecs.push_back(t);
        end
        vecs.push_back(mk("mc",    0, 0,  1, 0, 1, 1, 5, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mf",    1, 99, 0, 0, 0, 1, 5, 1, 0, 1, 0, 0));
        vecs.push_back(mk("rb24",  0, 0,  0, 0, 0, 0, 5, 0, 0, 0, 1, 0));
        vecs.push_back(mk("rb23",  0, 0,  0, 0, 0, 0, 4, 0, 0, 0, 1, 0));
        vecs.push_back(mk("rb22",  0, 0,  0, 0, 0, 0, 3, 0, 0, 0, 1, 0));
        vecs.push_back(mk("rb21",  0, 0,  0, 0, 0, 0, 2, 0, 0, 0, 1, 0));
        vecs.push_back(mk("mdone", 0, 0,  0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
        t = mk("mrun", 1, 30, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0); t.chk_fid = 1; t.fid = 20; vecs.push_back(t);
        vecs.push_back(mk("mc30",  0, 0,  1, 1, 0, 1, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mk30",  0, 0,  0, 0, 0, 1, 2, 1, 0, 0, 0, 0));

        // Mispredict on the only entry: flush_done on the very next cycle.
        t = mk("s40", 1, 40, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0); t.rst_b4 = 1; vecs.push_back(t);
        vecs.push_back(mk("sc", 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sf", 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk("sd", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
        t = mk("sr", 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0); t.chk_fid = 1; t.fid = 40; vecs.push_back(t);

        // Start a walk; the reset lands in its second cycle below.
        for (int i = 0; i < 4; i++) begin
            t = mk("wd", 1, 50 + i, 0, 0, 0, 1, i, 0, (i == 0), 0, 0, 0);
            t.rst_b4 = (i == 0);
            vecs.push_back(t);
        end
        vecs.push_back(mk("wc", 0, 0, 1, 0, 1, 1, 4, 0, 0, 0, 0, 0));
        vecs.push_back(mk("wf", 0, 0, 0, 0, 0, 1, 4, 1, 0, 1, 0, 0));
        vecs.push_back(mk("w1", 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Still in WALK with entries left: reset must abort without flush_done.
        chk("walk.pre_rst_rb", 64'(rollback_valid), 64'd1);
        do_reset("walkrst");
        chk("walkrst.alloc", 64'(alloc_index), 64'd0);
        chk("walkrst.empty", 64'(empty), 64'd1);
        @(posedge clk); #1;
        chk("walkrst.fdone_after", 64'(flush_done), 64'd0);
        chk("walkrst.ready_after", 64'(disp_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
